// File: rtl/gates_df_checker.sv
// Self-checking response block for the two-input gate unit. Walks {a,b}
// through 00..11, waits SETTLE_CYCLES per vector, then compares the seven
// gate outputs against the truth table and accumulates the results.

// One compare lane: flags a single gate output that disagrees with its expected value.
module gates_df_chk_lane (
  input  logic exp_bit,
  input  logic act_bit,
  output logic mis
);
  assign mis = exp_bit ^ act_bit;
endmodule

module gates_df_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y_not,
  input  logic       y_and,
  input  logic       y_or,
  input  logic       y_nand,
  input  logic       y_nor,
  input  logic       y_xor,
  input  logic       y_xnor,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [6:0] mismatch_mask,
  output logic [1:0] first_fail_vec
);
  localparam int NUM_OUT = 7;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         vec_q;
  logic [3:0]         cnt_q;
  logic               cnt_last;
  logic [NUM_OUT-1:0] exp_y, act_y, mis;
  logic               any_mis;

  // Stimulus comes straight from the vector register, so a/b are glitch-free.
  assign {a, b}   = vec_q;
  assign cnt_last = (cnt_q == 4'(SETTLE_CYCLES - 1));

  // Bit order: [0]not [1]and [2]or [3]nand [4]nor [5]xor [6]xnor.
  assign exp_y = {~(vec_q[1] ^ vec_q[0]), vec_q[1] ^ vec_q[0],
                  ~(vec_q[1] | vec_q[0]), ~(vec_q[1] & vec_q[0]),
                  vec_q[1] | vec_q[0], vec_q[1] & vec_q[0], ~vec_q[1]};
  assign act_y = {y_xnor, y_xor, y_nor, y_nand, y_or, y_and, y_not};

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
    gates_df_chk_lane u_lane (
      .exp_bit (exp_y[i]),
      .act_bit (act_y[i]),
      .mis     (mis[i])
    );
  end

  assign any_mis = |mis;

  // Status is a pure decode of the state register.
  assign busy = (state_q == APPLY) || (state_q == CHECK);
  assign done = (state_q == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: settle per vector, check once, stop after vector 3.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = APPLY;
      APPLY:   if (cnt_last) state_d = CHECK;
      CHECK:   state_d = (vec_q == 2'd3) ? DONE : APPLY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Vector/settle counters and result accumulation; y_* only sampled leaving CHECK.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_q          <= '0;
      cnt_q          <= '0;
      err_count      <= '0;
      mismatch_mask  <= '0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            vec_q          <= '0;
            cnt_q          <= '0;
            err_count      <= '0;
            mismatch_mask  <= '0;
            first_fail_vec <= '0;
            pass           <= 1'b0;
          end
        end
        APPLY: cnt_q <= cnt_q + 4'd1;
        CHECK: begin
          mismatch_mask <= mismatch_mask | mis;
          if (any_mis) begin
            err_count <= err_count + 3'd1;
            if (err_count == 3'd0) first_fail_vec <= vec_q;
          end
          cnt_q <= '0;
          if (vec_q == 2'd3) begin
            // Leaving the last CHECK: pass is valid in the DONE cycle.
            vec_q <= '0;
            pass  <= (err_count == 3'd0) && !any_mis;
          end else begin
            vec_q <= vec_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gates_df_checker.sv
// Bench for gates_df_checker: a faultable gate-unit model feeds two checkers
// (settle 2 and settle 1); a scoreboard queue holds each run's expected
// results, popped by a monitor whenever a checker pulses done.
module tb_gates_df_checker;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start;
  logic [1:0] a, b, busy, done, pass;
  logic [2:0] err   [2];
  logic [6:0] mask  [2];
  logic [1:0] ffv   [2];
  logic [6:0] y     [2];
  logic [6:0] flip  [2][4];   // per-DUT, per-vector output inversions (fault model)
  int         cyc = 0;
  int         n_pass = 0, n_total = 0;

  typedef struct {
    int         start_cyc;
    logic       pass;
    logic [2:0] err;
    logic [6:0] mask;
    logic [1:0] ffv;
  } exp_t;
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gates_df_checker #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a[0]), .b(b[0]),
    .y_not(y[0][0]), .y_and(y[0][1]), .y_or(y[0][2]), .y_nand(y[0][3]),
    .y_nor(y[0][4]), .y_xor(y[0][5]), .y_xnor(y[0][6]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err[0]),
    .mismatch_mask(mask[0]), .first_fail_vec(ffv[0]));

  gates_df_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a[1]), .b(b[1]),
    .y_not(y[1][0]), .y_and(y[1][1]), .y_or(y[1][2]), .y_nand(y[1][3]),
    .y_nor(y[1][4]), .y_xor(y[1][5]), .y_xnor(y[1][6]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err[1]),
    .mismatch_mask(mask[1]), .first_fail_vec(ffv[1]));

  function automatic logic [6:0] golden(input logic ai, input logic bi);
    return {~(ai ^ bi), ai ^ bi, ~(ai | bi), ~(ai & bi), ai | bi, ai & bi, ~ai};
  endfunction

  // Gate unit under test: golden truth table with injected inversions.
  always_comb begin
    for (int d = 0; d < 2; d++) y[d] = golden(a[d], b[d]) ^ flip[d][{a[d], b[d]}];
  end

  // Reference: a vector fails iff any of its outputs is inverted.
  function automatic exp_t model(input int d, input int k);
    exp_t e;
    e.start_cyc = k; e.err = 0; e.mask = 0; e.ffv = 0;
    for (int v = 0; v < 4; v++) begin
      if (flip[d][v] != 7'd0) begin
        if (e.err == 0) e.ffv = 2'(v);
        e.err  = e.err + 3'd1;
        e.mask = e.mask | flip[d][v];
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, expv, $time);
  endtask

  task automatic push(input int d, input int k);
    if (d == 0) q0.push_back(model(d, k));
    else        q1.push_back(model(d, k));
  endtask

  task automatic set_flips(input int d, input logic [6:0] f0, input logic [6:0] f1,
                           input logic [6:0] f2, input logic [6:0] f3);
    flip[d][0] = f0; flip[d][1] = f1; flip[d][2] = f2; flip[d][3] = f3;
  endtask

  task automatic rand_flips(input int d);
    for (int v = 0; v < 4; v++)
      flip[d][v] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'd0;
  endtask

  task automatic chk_idle(input int d, input string nm);
    chk({nm, "_ab"}, {a[d], b[d]}, 0);
    chk({nm, "_busy"}, busy[d], 0);
    chk({nm, "_done"}, done[d], 0);
    chk({nm, "_pass"}, pass[d], 0);
    chk({nm, "_err"}, err[d], 0);
    chk({nm, "_mask"}, mask[d], 0);
    chk({nm, "_ffv"}, ffv[d], 0);
  endtask

  // One run: start pulse (or held), trace a/b and busy each cycle until done.
  task automatic run(input int d, input bit hold, output int k);
    int s, len;
    s = (d == 0) ? 2 : 1;
    len = 4 * (s + 1);
    @(negedge clk);
    start[d] = 1'b1;
    k = cyc + 1;
    push(d, k);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (!hold) start[d] = 1'b0;
      chk("trace_ab", {a[d], b[d]}, i / (s + 1));
      chk("trace_busy", busy[d], 1);
    end
    @(negedge clk);
    chk("done_busy_low", busy[d], 0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    int   s;
    for (int d = 0; d < 2; d++) begin
      if (done[d] === 1'b1) begin
        s = (d == 0) ? 2 : 1;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          n_total++;
          $display("FAIL unexpected_done dut%0d actual=done expected=no_done t=%0t", d, $time);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk("latency", cyc - e.start_cyc, 4 * (s + 1));
          chk("pass", pass[d], e.pass);
          chk("err_count", err[d], e.err);
          chk("mismatch_mask", mask[d], e.mask);
          chk("first_fail_vec", ffv[d], e.ffv);
          chk("done_ab_zero", {a[d], b[d]}, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    start = 2'b00;
    set_flips(0, 0, 0, 0, 0);
    set_flips(1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk_idle(0, "rst0");
    chk_idle(1, "rst1");
    rst_n = 1'b1;

    // Correct unit, y_and stuck at 0, xor/xnor swapped.
    run(0, 1'b0, k);
    set_flips(0, 0, 0, 0, 7'b0000010);
    run(0, 1'b0, k);
    set_flips(0, 7'b1100000, 7'b1100000, 7'b1100000, 7'b1100000);
    run(0, 1'b0, k);

    // Start held high: one run, one IDLE cycle, then a fresh run with cleared results.
    set_flips(0, 7'b0010000, 0, 7'b0000100, 0);
    run(0, 1'b1, k);
    set_flips(0, 0, 0, 0, 0);
    push(0, k + 14);
    @(negedge clk);
    chk("held_idle_busy", busy[0], 0);
    chk("held_idle_done", done[0], 0);
    @(negedge clk);
    start[0] = 1'b0;
    chk("held_rerun_busy", busy[0], 1);
    chk("held_rerun_err", err[0], 0);
    chk("held_rerun_mask", mask[0], 0);
    chk("held_rerun_ffv", ffv[0], 0);
    chk("held_rerun_pass", pass[0], 0);
    repeat (13) @(negedge clk);

    // Random fault patterns.
    for (int r = 0; r < 6; r++) begin
      rand_flips(0);
      run(0, 1'b0, k);
    end

    // Reset during vector 10's APPLY: partial results must vanish, no done follows.
    set_flips(0, 0, 7'b0000001, 0, 0);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrun_ab", {a[0], b[0]}, 2);
    chk("midrun_err", err[0], 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle(0, "midrun_rst");
    repeat (20) begin
      @(negedge clk);
      chk("post_rst_busy", busy[0], 0);
    end

    // Settle of 1: two cycles per vector.
    set_flips(1, 0, 0, 0, 0);
    run(1, 1'b0, k);
    for (int r = 0; r < 3; r++) begin
      rand_flips(1);
      run(1, 1'b0, k);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/gates_df_checker.md
# gates_df_checker

Self-checking response block for the two-input gate data-flow unit (`gates_df`). It drives all four `{a,b}` input vectors into the gate unit and samples the seven gate outputs after a programmable settle time. It compares each output against the expected truth table and reports pass/fail, a sticky per-output mismatch mask and a failure count. It sits opposite the gate unit on the same `a`/`b`/`y_*` interface, so the gate unit can be checked on-chip or in a synthesizable bench without a behavioural stimulus file.

## Interface
- `SETTLE_CYCLES`, default 2: cycles `{a,b}` is held before the outputs are compared. Legal range is 1..15.
- `clk`  in  1  : single clock; all state changes on the rising edge.
- `rst_n`  in  1  : synchronous, active-low reset.
- `start`  in  1  : begins a check run; sampled only in IDLE.
- `a`, `b`  out  1 each  : stimulus to the gate unit.
- `y_not`, `y_and`, `y_or`, `y_nand`, `y_nor`, `y_xor`, `y_xnor`  in  1 each  : gate unit outputs.
- `busy`  out  1  : high in APPLY and CHECK.
- `done`  out  1  : one-cycle pulse at the end of a run.
- `pass`  out  1  : high when the last completed run had no mismatch.
- `err_count`  out  3  : number of vectors with at least one mismatch (0..4).
- `mismatch_mask`  out  7  : sticky OR of per-output mismatches. Bit order is [0]not, [1]and, [2]or, [3]nand, [4]nor, [5]xor, [6]xnor.
- `first_fail_vec`  out  2  : `{a,b}` of the first failing vector; 0 if none.

## Operation
- Expected values, with a and b as the applied vector:
  - `not` = ~a
  - `and` = a&b
  - `or` = a|b
  - `nand` = ~(a&b)
  - `nor` = ~(a|b)
  - `xor` = a^b
  - `xnor` = ~(a^b)
- States are IDLE, APPLY, CHECK and DONE. Registers:
  - 2-bit `vec`
  - 4-bit settle counter `cnt`
  - result registers (`err_count`, `mismatch_mask`, `first_fail_vec`, `pass`)
- `{a,b}` = `vec` in every state. In IDLE and DONE, `vec` is 0.
- IDLE: if `start`=1, go to APPLY with `vec`=0 and `cnt`=0. Also clear `err_count`, `mismatch_mask`, `first_fail_vec` and `pass`.
- APPLY: `cnt` increments each cycle. When `cnt`=SETTLE_CYCLES-1, go to CHECK.
- CHECK: compute the 7-bit mismatch of the `y_*` inputs against expected, then:
  - OR the mismatch into `mismatch_mask`.
  - If the mismatch is non-zero, increment `err_count`.
  - If it is non-zero and `err_count` was 0, load `first_fail_vec` = `vec`.
  - If `vec`=3, go to DONE. Otherwise `vec`+1, `cnt`=0, and go to APPLY.
- DONE: `done`=1 for this one cycle. `pass` = (final `err_count`==0), valid from this cycle. Next state is IDLE.
- Results hold until the next accepted `start` or reset.
- `start` in APPLY, CHECK or DONE is ignored and not queued.
- `err_count` cannot exceed 4. No wrap handling is needed.

## Timing
- Reset (`rst_n`=0 at an edge) takes effect from any state, including mid-run: state IDLE, `a`=`b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `mismatch_mask`=0, `first_fail_vec`=0, `vec`=0, `cnt`=0. No partial results survive.
- Outputs `a`/`b` are registered (driven from `vec`). `busy`/`done` are decoded from the state register, so there are no combinational paths from the `y_*` inputs to any output.
- Let `start` be sampled at edge k:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - The CHECK for vector n is the cycle after edge k+n(SETTLE_CYCLES+1)+SETTLE_CYCLES.
  - DONE is entered at edge k+4(SETTLE_CYCLES+1). With the default, `done` is high in the cycle after edge k+12.
- The `y_*` inputs are sampled only at the edge that leaves CHECK. They may glitch at any other time.
- `busy` falls on entry to DONE, in the same cycle `done` rises.

## Test plan
- Correct gate unit, SETTLE_CYCLES=2, `start` pulse → `a,b` steps 00,01,10,11 with 3 cycles each. `done` pulses 12 cycles after the start edge with `pass`=1, `err_count`=0, `mismatch_mask`=7'h00, `first_fail_vec`=0.
- `y_and` stuck at 0 → only vector 11 fails: `err_count`=1, `mismatch_mask`=7'b0000010, `first_fail_vec`=2'b11, `pass`=0.
- `y_xor` and `y_xnor` swapped → all vectors fail: `err_count`=4, `mismatch_mask`=7'b1100000, `first_fail_vec`=2'b00.
- `start` held high for the whole run → exactly one run. Then IDLE for 1 cycle, and a second run starts on the next sampled `start` with results cleared at that edge.
- `rst_n` low for 1 cycle during vector 10's APPLY → the next cycle shows IDLE reset values on every output. No `done` pulse follows.
- SETTLE_CYCLES=1, correct unit → 2 cycles per vector, `done` 8 cycles after the start edge, `pass`=1.
